// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Shared opcodes, FSM state type and result-entry layout for
//               the ALU execution unit and its result FIFO.
//               Optional macro ALU_OVF_EN adds a signed-overflow bit to the
//               result entry.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    // Natural datapath width; the result-entry layout is built on it
    localparam int ALU_W = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] w;
        logic             zer;
        logic             neg;
`ifdef ALU_OVF_EN
        logic             ovf;
`endif
    } alu_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Synchronous FIFO for ALU result entries. Occupancy counter
//               drives full/empty; the head reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CNTW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the counter
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Handshaked ALU execution wrapper. Single-cycle ops push their
//               result at the accept edge; MUL runs a W-step shift-add loop.
//               Results return in order through a small FIFO.
//               Optional macro ALU_OVF_EN adds rsp_ovf (signed overflow of
//               ADD/SUB, stored per entry).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_opc,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_w,
    output logic         rsp_zer,
    output logic         rsp_neg
`ifdef ALU_OVF_EN
    ,
    output logic         rsp_ovf
`endif
);
    localparam int CW = $clog2(W) + 1;
    localparam int EW = $bits(alu_entry_t);

    alu_state_e    state_q;
    logic [W-1:0]  mul_a_q;
    logic [W-1:0]  mul_b_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [CW-1:0] cnt_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          mul_done;
    logic          push;
    logic          pop;
    logic [W-1:0]  alu_w;
    logic [W-1:0]  push_w;
    alu_entry_t    push_entry;
    alu_entry_t    head_entry;
    logic [EW-1:0] head_vec;

    // Ready looks only at registered state, never at rsp_ready
    assign req_ready = !rst && (state_q == S_IDLE) && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign mul_done  = (state_q == S_MUL) && (cnt_q == CW'(W - 1));
    assign acc_d     = acc_q + (mul_b_q[0] ? mul_a_q : '0);

    // Single-cycle opcode decode; MUL is produced by the iterative loop
    always_comb begin
        alu_w = '0;
        case (req_opc)
            OP_ADD:  alu_w = req_a + req_b + {{(W-1){1'b0}}, req_cin};
            OP_SUB:  alu_w = req_a - req_b - {{(W-1){1'b0}}, req_cin};
            OP_AND:  alu_w = req_a & req_b;
            OP_OR:   alu_w = req_a | req_b;
            OP_XOR:  alu_w = req_a ^ req_b;
            OP_NOT:  alu_w = ~req_a;
            OP_SLT:  alu_w = {{(W-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
            default: alu_w = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic [W:0] ovf_sum;
    logic       alu_ovf;

    // One extra sign bit holds the exact ADD/SUB value; overflow when the
    // top two bits disagree
    always_comb begin
        ovf_sum = '0;
        alu_ovf = 1'b0;
        if (req_opc == OP_ADD) begin
            ovf_sum = {req_a[W-1], req_a} + {req_b[W-1], req_b} + {{W{1'b0}}, req_cin};
            alu_ovf = ovf_sum[W] ^ ovf_sum[W-1];
        end else if (req_opc == OP_SUB) begin
            ovf_sum = {req_a[W-1], req_a} - {req_b[W-1], req_b} - {{W{1'b0}}, req_cin};
            alu_ovf = ovf_sum[W] ^ ovf_sum[W-1];
        end
    end
`endif

    // Build the FIFO entry from whichever source pushes this cycle
    always_comb begin
        push_w         = mul_done ? acc_d : alu_w;
        push_entry     = '0;
        push_entry.w   = push_w;
        push_entry.zer = (push_w == '0);
        push_entry.neg = push_w[W-1];
`ifdef ALU_OVF_EN
        push_entry.ovf = !mul_done && alu_ovf;
`endif
    end

    assign push = (accept && (req_opc != OP_MUL)) || mul_done;
    assign pop  = rsp_valid && rsp_ready;

    // Control FSM and shift-add multiplier; reset discards any MUL in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && (req_opc == OP_MUL)) begin
                        mul_a_q <= req_a;
                        mul_b_q <= req_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q   <= acc_d;
                    mul_a_q <= mul_a_q << 1;
                    mul_b_q <= mul_b_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (mul_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    alu_result_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_vec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_entry = alu_entry_t'(head_vec);
    assign rsp_valid  = !fifo_empty;
    assign rsp_w      = head_entry.w;
    assign rsp_zer    = head_entry.zer;
    assign rsp_neg    = head_entry.neg;
`ifdef ALU_OVF_EN
    assign rsp_ovf    = head_entry.ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit. Expected results are
//               queued when a request is accepted and compared when the
//               consumer takes the head. Honours ALU_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_opc;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_w;
    logic        rsp_zer;
    logic        rsp_neg;
`ifdef ALU_OVF_EN
    logic        rsp_ovf;
`endif

    typedef struct {
        logic [15:0] w;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_exec_unit #(.W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opc   (req_opc),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_w     (rsp_w),
        .rsp_zer   (rsp_zer),
        .rsp_neg   (rsp_neg)
`ifdef ALU_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the opcode table
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        exp_t        e;
        int          sa;
        int          sbv;
        int          c;
        int          s;
        logic [31:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        c   = cin ? 1 : 0;
        e.ovf = 1'b0;
        case (op)
            3'd0: begin s = sa + sbv + c; e.w = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sbv - c; e.w = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
            3'd2: e.w = a & b;
            3'd3: e.w = a | b;
            3'd4: e.w = a ^ b;
            3'd5: e.w = ~a;
            3'd6: e.w = (sa < sbv) ? 16'd1 : 16'd0;
            default: begin p = {16'd0, a} * {16'd0, b}; e.w = p[15:0]; end
        endcase
        return e;
    endfunction

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_opc = 3'd0; req_a = '0; req_b = '0; req_cin = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_w !== 16'h0 || rsp_zer !== 1'b0 ||
            rsp_neg !== 1'b0 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b w=%h zer=%b neg=%b ready=%b, required all 0",
                     rsp_valid, rsp_w, rsp_zer, rsp_neg, req_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_add;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_opc = 3'd0; req_a = 16'h7FFF; req_b = 16'h0001; req_cin = 1'b0;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_ready: ready=%b, required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'h8000 || rsp_neg !== 1'b1 || rsp_zer !== 1'b0
`ifdef ALU_OVF_EN
            || rsp_ovf !== 1'b1
`endif
            ) begin
            tests_failed++;
            $display("FAIL add_result: valid=%b w=%h zer=%b neg=%b, required valid=1 w=8000 zer=0 neg=1",
                     rsp_valid, rsp_w, rsp_zer, rsp_neg);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_drain: valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops [2];
        logic [15:0] as_ [2];
        logic [15:0] bs_ [2];
        exp_t        e;
        ops[0] = 3'd1; as_[0] = 16'h0005; bs_[0] = 16'h0005;
        ops[1] = 3'd6; as_[1] = 16'hFFFF; bs_[1] = 16'h0001;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_extra: w=%h, required no response", rsp_w);
                end else begin
                    e = sb.pop_front();
                    if (rsp_w !== e.w || rsp_zer !== (e.w == 16'h0) || rsp_neg !== e.w[15]) begin
                        tests_failed++;
                        $display("FAIL b2b_result: w=%h zer=%b neg=%b, required w=%h", rsp_w, rsp_zer, rsp_neg, e.w);
                    end
                end
            end else if (i >= 1 && i <= 2) begin
                tests_run++;
                tests_failed++;
                $display("FAIL b2b_gap: valid=%b in cycle %0d, required 1", rsp_valid, i);
            end
            if (i < 2) begin
                req_valid = 1'b1; req_opc = ops[i]; req_a = as_[i]; req_b = bs_[i]; req_cin = 1'b0;
                tests_run++;
                if (req_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_ready: ready=%b in cycle %0d, required 1", req_ready, i);
                end
                if (req_ready) sb.push_back(model(ops[i], as_[i], bs_[i], 1'b0));
            end else begin
                req_valid = 1'b0;
            end
        end
        tests_run++;
        if (rsp_valid !== 1'b0 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: valid=%b pending=%0d, required 0 0", rsp_valid, sb.size());
        end
    endtask

    task automatic test_mul;
        int  lat;
        logic bad;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_opc = 3'd7; req_a = 16'h0102; req_b = 16'h0003; req_cin = 1'b1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_ready: ready=%b, required 1", req_ready);
        end
        bad = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL mul_busy: ready/valid high during cycles 1..16, required 0");
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'h0306 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_result: valid=%b w=%h ready=%b, required valid=1 w=0306 ready=1",
                     rsp_valid, rsp_w, req_ready);
        end
        req_valid = 1'b1; req_opc = 3'd7; req_a = 16'hFFFF; req_b = 16'hFFFF; req_cin = 1'b0;
        lat = 0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'h0001 || lat != 17) begin
            tests_failed++;
            $display("FAIL mul_ffff: valid=%b w=%h latency=%0d, required valid=1 w=0001 latency=17",
                     rsp_valid, rsp_w, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int   cyc;
        int   got;
        logic fifth_acc;
        exp_t e;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_opc = 3'd0; req_a = 16'(i + 1); req_b = 16'h0; req_cin = 1'b0;
            tests_run++;
            if (req_ready !== (i < 4)) begin
                tests_failed++;
                $display("FAIL bp_ready_%0d: ready=%b, required %b", i, req_ready, (i < 4));
            end
            if (req_ready) sb.push_back(model(3'd0, 16'(i + 1), 16'h0, 1'b0));
        end
        cyc = 0; got = 0; fifth_acc = 1'b0;
        while (got < 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (fifth_acc) req_valid = 1'b0;
            rsp_ready = 1'b1;
            if (cyc == 1) begin
                tests_run++;
                if (req_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_full_pop: ready=%b while full and popping, required 0", req_ready);
                end
            end
            if (rsp_valid && rsp_ready) begin
                tests_run++;
                got++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_extra: w=%h, required no response", rsp_w);
                end else begin
                    e = sb.pop_front();
                    if (rsp_w !== e.w) begin
                        tests_failed++;
                        $display("FAIL bp_order: w=%h, required %h", rsp_w, e.w);
                    end
                end
            end
            if (req_valid && req_ready) begin
                sb.push_back(model(3'd0, 16'd5, 16'h0, 1'b0));
                fifth_acc = 1'b1;
            end
        end
        req_valid = 1'b0;
        tests_run++;
        if (got != 5 || !fifth_acc || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_count: returned=%0d fifth_accepted=%b pending=%0d, required 5 1 0",
                     got, fifth_acc, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul;
        logic bad;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_opc = 3'd0; req_a = 16'd1; req_b = 16'd1; req_cin = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_opc = 3'd7; req_a = 16'd3; req_b = 16'd5;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmul_accept: ready=%b, required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'd2) begin
            tests_failed++;
            $display("FAIL rmul_queued: valid=%b w=%h, required valid=1 w=0002", rsp_valid, rsp_w);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_w !== 16'h0 || rsp_zer !== 1'b0 || rsp_neg !== 1'b0 ||
            req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmul_async: valid=%b w=%h zer=%b neg=%b ready=%b, required all 0",
                     rsp_valid, rsp_w, rsp_zer, rsp_neg, req_ready);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL rmul_stale: response seen after reset, required none");
        end
        req_valid = 1'b1; req_opc = 3'd0; req_a = 16'd2; req_b = 16'd3; req_cin = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'h0005) begin
            tests_failed++;
            $display("FAIL rmul_after: valid=%b w=%h, required valid=1 w=0005", rsp_valid, rsp_w);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int          issued;
        int          cyc;
        logic        acc_pending;
        exp_t        e;
        logic [15:0] edge_v [5];
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        c;
        edge_v[0] = 16'h0000; edge_v[1] = 16'h0001; edge_v[2] = 16'h7FFF;
        edge_v[3] = 16'h8000; edge_v[4] = 16'hFFFF;
        issued = 0; cyc = 0; acc_pending = 1'b0;
        req_valid = 1'b0;
        while ((issued < 1000 || sb.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (rsp_valid && rsp_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra: w=%h, required no response", rsp_w);
                end else begin
                    e = sb.pop_front();
                    if (rsp_w !== e.w || rsp_zer !== (e.w == 16'h0) || rsp_neg !== e.w[15]
`ifdef ALU_OVF_EN
                        || rsp_ovf !== e.ovf
`endif
                        ) begin
                        tests_failed++;
                        $display("FAIL rand_result: w=%h zer=%b neg=%b, required w=%h zer=%b neg=%b",
                                 rsp_w, rsp_zer, rsp_neg, e.w, (e.w == 16'h0), e.w[15]);
                    end
                end
            end
            if (acc_pending) begin
                req_valid = 1'b0;
                acc_pending = 1'b0;
            end
            if (!req_valid && issued < 1000 && $urandom_range(0, 9) < 8) begin
                op = 3'($urandom_range(0, 7));
                a  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
                b  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
                c  = 1'($urandom_range(0, 1));
                req_valid = 1'b1; req_opc = op; req_a = a; req_b = b; req_cin = c;
            end else if (!req_valid) begin
                req_opc = 'x; req_a = 'x; req_b = 'x; req_cin = 'x;
            end
            if (req_valid && req_ready) begin
                sb.push_back(model(req_opc, req_a, req_b, req_cin));
                issued++;
                acc_pending = 1'b1;
            end
        end
        req_valid = 1'b0;
        tests_run++;
        if (issued != 1000 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_complete: issued=%0d pending=%0d, required 1000 0", issued, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
